// File: rtl/mul_share_arbiter.sv
// Two-requester front end for one 2-stage W x W unsigned multiplier with credit-gated issue and per-requester result FIFOs.
// Build option: define MUL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mul_share_arbiter #(
   parameter int W     = 4,
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           res0_valid,
   input  logic           res0_ready,
   output logic [2*W-1:0] res0_data,
   output logic           res1_valid,
   input  logic           res1_ready,
   output logic [2*W-1:0] res1_data,
   output logic           busy
);

   localparam int PW = 2 * W;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

   // Handshake: a transfer happens in any cycle where valid & ready are both high;
   // the producer keeps valid and payload stable until then. req ready is
   // combinational from valid, credits and arbitration state only.

   logic [1:0]    req_valid;
   logic [1:0]    res_ready;
   logic [1:0]    res_valid;
   logic [1:0]    pop;
   logic [1:0]    push;
   logic [1:0]    elig;
   logic [1:0]    gnt;
   logic          acc;
   logic          sel;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [PW-1:0] pp;
   logic [PW-1:0] half_lo;
   logic [PW-1:0] half_hi;
   logic [PW-1:0] product;
   logic [CW:0]   occ [2];

   logic          s1_valid;
   logic          s1_tag;
   logic [PW-1:0] s1_lo;
   logic [PW-1:0] s1_hi;

   logic [PW-1:0] mem    [2][DEPTH];
   logic [AW-1:0] rd_ptr [2];
   logic [AW-1:0] wr_ptr [2];
   logic [CW-1:0] count  [2];

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   assign req_valid = {req1_valid, req0_valid};
   assign res_ready = {res1_ready, res0_ready};

   // Occupancy counts the stage-1 slot as well, so an accepted op always has a FIFO slot waiting.
   always_comb begin
      for (int r = 0; r < 2; r++) begin
         res_valid[r] = ~rst & (count[r] != '0);
         pop[r]       = res_valid[r] & res_ready[r];
         push[r]      = s1_valid & (s1_tag == 1'(r));
         occ[r]       = {1'b0, count[r]} + {{CW{1'b0}}, push[r]};
         elig[r]      = req_valid[r] & ((occ[r] - {{CW{1'b0}}, pop[r]}) < DEPTH_C);
      end
   end

`ifdef MUL_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt[0] = ~rst & elig[0];
      gnt[1] = ~rst & elig[1] & ~elig[0];
   end
`else
   logic last_gnt;  // requester granted most recently; reset to 1 so requester 0 wins first

   always_comb begin
      gnt[0] = ~rst & elig[0] & (~elig[1] | last_gnt);
      gnt[1] = ~rst & elig[1] & (~elig[0] | ~last_gnt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= 1'b1;
      end else if (acc) begin
         last_gnt <= sel;
      end
   end
`endif

   assign acc        = |gnt;
   assign sel        = gnt[1];
   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   assign op_a = sel ? req1_a : req0_a;
   assign op_b = sel ? req1_b : req0_b;

   // Stage 1 datapath: partial products split into a low-half and a high-half sum.
   always_comb begin
      half_lo = '0;
      half_hi = '0;
      pp      = '0;
      for (int j = 0; j < W; j++) begin
         pp = PW'(op_a & {W{op_b[j]}}) << j;
         if (j < W / 2) begin
            half_lo = half_lo + pp;
         end else begin
            half_hi = half_hi + pp;
         end
      end
   end

   assign product = s1_lo + s1_hi;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_tag   <= 1'b0;
         s1_lo    <= '0;
         s1_hi    <= '0;
         for (int r = 0; r < 2; r++) begin
            rd_ptr[r] <= '0;
            wr_ptr[r] <= '0;
            count[r]  <= '0;
         end
      end else begin
         s1_valid <= acc;
         if (acc) begin
            s1_tag <= sel;
            s1_lo  <= half_lo;
            s1_hi  <= half_hi;
         end
         // Stage 2: final add lands directly in the owner's FIFO.
         for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
               mem[r][wr_ptr[r]] <= product;
               wr_ptr[r]         <= ptr_inc(wr_ptr[r]);
            end
            if (pop[r]) begin
               rd_ptr[r] <= ptr_inc(rd_ptr[r]);
            end
            count[r] <= count[r] + CW'(push[r]) - CW'(pop[r]);
         end
      end
   end

   assign res0_valid = res_valid[0];
   assign res1_valid = res_valid[1];
   assign res0_data  = res_valid[0] ? mem[0][rd_ptr[0]] : '0;
   assign res1_data  = res_valid[1] ? mem[1][rd_ptr[1]] : '0;
   assign busy       = ~rst & (s1_valid | (count[0] != '0) | (count[1] != '0));

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: acceptances push hand-computed products into per-requester
// expected queues; a negedge monitor pops and compares whenever a result is consumed.
module tb_mul_share_arbiter;

   localparam int W  = 4;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic          res0_valid, res1_valid;
   logic          res0_ready = 1'b1, res1_ready = 1'b1;
   logic [PW-1:0] res0_data, res1_data;
   logic          busy;

   mul_share_arbiter #(.W(W), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_data(res0_data),
      .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_data(res1_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Vector tables: operands and hand-computed products.
   logic [W-1:0]  v0_a [32], v0_b [32], v1_a [32], v1_b [32];
   logic [PW-1:0] v0_e [32], v1_e [32];
   int            n0 = 0, n1 = 0, idx0 = 0, idx1 = 0;
   bit            feed0 = 0, feed1 = 0, log_en = 0, strict = 0;

   logic [PW-1:0] exp0_q [$];
   logic [PW-1:0] exp1_q [$];
   int            lat0_q [$];
   int            lat1_q [$];
   int            log_who [$];
   int            log_cyc [$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Drivers: present the current vector from 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (feed0 && idx0 < n0) begin
            req0_valid = 1'b1; req0_a = v0_a[idx0]; req0_b = v0_b[idx0];
         end else begin
            req0_valid = 1'b0;
         end
         if (feed1 && idx1 < n1) begin
            req1_valid = 1'b1; req1_a = v1_a[idx1]; req1_b = v1_b[idx1];
         end else begin
            req1_valid = 1'b0;
         end
      end
   end

   task automatic check_res(input int r, input logic v, input logic rd, input logic [PW-1:0] d);
      logic [PW-1:0] e;
      int            c;
      if (v && rd) begin
         if ((r == 0) ? (exp0_q.size() == 0) : (exp1_q.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL res%0d_unexpected: got=%0h want=none (cycle %0d)", r, d, cyc);
         end else begin
            if (r == 0) begin e = exp0_q.pop_front(); c = lat0_q.pop_front(); end
            else        begin e = exp1_q.pop_front(); c = lat1_q.pop_front(); end
            chk($sformatf("res%0d_data", r), 32'(d), 32'(e));
            if (strict) chk($sformatf("res%0d_latency", r), cyc, c + 2);
         end
      end else if (!v) begin
         chk($sformatf("res%0d_idle_data", r), 32'(d), 0);
      end
   endtask

   // Acceptance recorder and result monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (req0_valid && req0_ready && req1_valid && req1_ready)
            chk("single_accept", 1, 0);
         if (req0_valid && req0_ready) begin
            exp0_q.push_back(v0_e[idx0]);
            lat0_q.push_back(cyc);
            if (log_en) begin log_who.push_back(0); log_cyc.push_back(cyc); end
            idx0++;
         end
         if (req1_valid && req1_ready) begin
            exp1_q.push_back(v1_e[idx1]);
            lat1_q.push_back(cyc);
            if (log_en) begin log_who.push_back(1); log_cyc.push_back(cyc); end
            idx1++;
         end
         if (!rst) begin
            check_res(0, res0_valid, res0_ready, res0_data);
            check_res(1, res1_valid, res1_ready, res1_data);
         end
      end
   end

   task automatic clear_sb();
      exp0_q.delete(); exp1_q.delete();
      lat0_q.delete(); lat1_q.delete();
      log_who.delete(); log_cyc.delete();
      idx0 = 0; idx1 = 0; n0 = 0; n1 = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; feed0 = 0; feed1 = 0;
      tick();
      clear_sb();
      rst = 1'b0;
   endtask

   task automatic check_rst_outputs(input string tag);
      chk({tag, "_req0_ready"}, 32'(req0_ready), 0);
      chk({tag, "_req1_ready"}, 32'(req1_ready), 0);
      chk({tag, "_res0_valid"}, 32'(res0_valid), 0);
      chk({tag, "_res1_valid"}, 32'(res1_valid), 0);
      chk({tag, "_res0_data"},  32'(res0_data), 0);
      chk({tag, "_res1_data"},  32'(res1_data), 0);
      chk({tag, "_busy"},       32'(busy), 0);
   endtask

   task automatic wait_accepts(input string tag, input int w0, input int w1, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (idx0 >= w0 && idx1 >= w1) break;
         tick();
      end
      chk({tag, "_accepts0"}, idx0, w0);
      chk({tag, "_accepts1"}, idx1, w1);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60; i++) begin
         if (idx0 == n0 && idx1 == n1 && exp0_q.size() == 0 && exp1_q.size() == 0) break;
         tick();
      end
      chk({tag, "_left0"}, exp0_q.size(), 0);
      chk({tag, "_left1"}, exp1_q.size(), 0);
      tick();
      @(negedge clk);
      chk({tag, "_idle_busy"}, 32'(busy), 0);
   endtask

   task automatic check_log(input string tag, input int n, input int n_zero);
      chk({tag, "_log_size"}, log_who.size(), n);
      for (int k = 1; k < n && k < log_cyc.size(); k++)
         chk($sformatf("%s_back_to_back_%0d", tag, k), log_cyc[k], log_cyc[0] + k);
      for (int k = 0; k < n_zero && k < log_who.size(); k++)
         chk($sformatf("%s_grant_%0d", tag, k), log_who[k], (n_zero == n) ? 0 : (k % 2));
   endtask

   logic [PW-1:0] t4_exp [16];

   initial begin
      t4_exp = '{8'h00, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69,
                 8'h78, 8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1};

      // Test 1: reset values, then a single 3 x 5 on requester 0.
      v0_a[0] = 4'd3; v0_b[0] = 4'd5; v0_e[0] = 8'h0F; n0 = 1; idx0 = 0;
      feed0 = 1; strict = 1;
      tick(); tick();
      @(negedge clk);
      check_rst_outputs("t1_rst");
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t1_first_ready", 32'(req0_ready), 1);
      drain("t1");

      // Test 2: both requesters always valid with 15 x 15.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         v0_a[k] = 4'd15; v0_b[k] = 4'd15; v0_e[k] = 8'hE1;
         v1_a[k] = 4'd15; v1_b[k] = 4'd15; v1_e[k] = 8'hE1;
      end
      n0 = 8; n1 = 8; strict = 1; log_en = 1;
      feed0 = 1; feed1 = 1;
      wait_accepts("t2", 8, 8, 40);
      log_en = 0;
`ifdef MUL_ARB_FIXED_PRIO_EN
      check_log("t2", 16, 8);
`else
      check_log("t2", 16, 16 - 1);
`endif
      drain("t2");

      // Test 3: requester 0 consumer stalled; requester 1 keeps flowing.
      do_reset();
      res0_ready = 1'b0; strict = 0;
      v0_a[0] = 4'd7;  v0_b[0] = 4'd9;  v0_e[0] = 8'h3F;
      v0_a[1] = 4'd2;  v0_b[1] = 4'd11; v0_e[1] = 8'h16;
      v0_a[2] = 4'd13; v0_b[2] = 4'd6;  v0_e[2] = 8'h4E;
      v1_a[0] = 4'd12; v1_b[0] = 4'd10; v1_e[0] = 8'h78;
      v1_a[1] = 4'd5;  v1_b[1] = 4'd5;  v1_e[1] = 8'h19;
      v1_a[2] = 4'd9;  v1_b[2] = 4'd14; v1_e[2] = 8'h7E;
      v1_a[3] = 4'd1;  v1_b[3] = 4'd1;  v1_e[3] = 8'h01;
      v1_a[4] = 4'd8;  v1_b[4] = 4'd8;  v1_e[4] = 8'h40;
      v1_a[5] = 4'd11; v1_b[5] = 4'd3;  v1_e[5] = 8'h21;
      n0 = 3; n1 = 6;
      feed0 = 1; feed1 = 1;
      repeat (10) tick();
      @(negedge clk);
      chk("t3_req0_accepts", idx0, 2);
      chk("t3_req1_accepts", idx1, 6);
      chk("t3_req0_blocked", 32'(req0_ready), 0);
      chk("t3_req0_pending", 32'(req0_valid), 1);
      chk("t3_res0_held", 32'(res0_valid), 1);
      tick();
      res0_ready = 1'b1;
      drain("t3");

      // Test 4: requester 0 alone, a = 0..15, b = 15, back to back.
      do_reset();
      for (int k = 0; k < 16; k++) begin
         v0_a[k] = 4'(k); v0_b[k] = 4'd15; v0_e[k] = t4_exp[k];
      end
      n0 = 16; strict = 1; log_en = 1;
      feed0 = 1;
      wait_accepts("t4", 16, 0, 40);
      log_en = 0;
      check_log("t4", 16, 16);
      drain("t4");

      // Test 5: reset with work in the pipe and in both FIFOs.
      do_reset();
      res0_ready = 1'b0; res1_ready = 1'b0; strict = 0;
      v0_a[0] = 4'd1; v0_b[0] = 4'd2; v0_e[0] = 8'h02;
      v0_a[1] = 4'd3; v0_b[1] = 4'd4; v0_e[1] = 8'h0C;
      v0_a[2] = 4'd5; v0_b[2] = 4'd6; v0_e[2] = 8'h1E;
      v1_a[0] = 4'd7; v1_b[0] = 4'd7; v1_e[0] = 8'h31;
      v1_a[1] = 4'd2; v1_b[1] = 4'd9; v1_e[1] = 8'h12;
      v1_a[2] = 4'd15; v1_b[2] = 4'd1; v1_e[2] = 8'h0F;
      n0 = 3; n1 = 3;
      feed0 = 1; feed1 = 1;
      repeat (4) tick();
      @(negedge clk);
      chk("t5_busy_before", 32'(busy), 1);
      tick();
      rst = 1'b1; feed0 = 0; feed1 = 0;
      @(negedge clk);
      check_rst_outputs("t5_rst");
      clear_sb();
      tick();
      rst = 1'b0; res0_ready = 1'b1; res1_ready = 1'b1;
      @(negedge clk);
      chk("t5_res0_valid", 32'(res0_valid), 0);
      chk("t5_res1_valid", 32'(res1_valid), 0);
      chk("t5_busy", 32'(busy), 0);
      repeat (10) tick();
      @(negedge clk);
      chk("t5_busy_end", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
